// File: rtl/control_unit_sequencer_pkg.sv
// rtl/control_unit_sequencer_pkg.sv - cu_pkg: states, opcodes, select encodings for the control sequencer
package cu_pkg;

    typedef enum logic [2:0] {
        RST     = 3'd0,
        FETCH_L = 3'd1,
        FETCH_H = 3'd2,
        DECODE  = 3'd3,
        EXEC    = 3'd4,
        HALT    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE = 3'd0,
        CL_BRA  = 3'd1,
        CL_BNE  = 3'd2,
        CL_LDI  = 3'd3,
        CL_ALU  = 3'd4,
        CL_HLT  = 3'd5
    } op_class_t;

    localparam logic [5:0] OP_BRA = 6'h00;
    localparam logic [5:0] OP_BNE = 6'h01;
    localparam logic [5:0] OP_LDI = 6'h02;
    localparam logic [5:0] OP_AND = 6'h04;
    localparam logic [5:0] OP_OR  = 6'h05;
    localparam logic [5:0] OP_NOT = 6'h06;
    localparam logic [5:0] OP_ADD = 6'h07;
    localparam logic [5:0] OP_SUB = 6'h08;
    localparam logic [5:0] OP_LSL = 6'h09;
    localparam logic [5:0] OP_LSR = 6'h0A;
    localparam logic [5:0] OP_XOR = 6'h0B;
    localparam logic [5:0] OP_HLT = 6'h3F;

    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_CLR  = 3'b011;

    localparam logic [4:0] ALU_AND = 5'b10111;
    localparam logic [4:0] ALU_OR  = 5'b11000;
    localparam logic [4:0] ALU_NOT = 5'b10010;
    localparam logic [4:0] ALU_ADD = 5'b10100;
    localparam logic [4:0] ALU_SUB = 5'b10110;
    localparam logic [4:0] ALU_LSL = 5'b11011;
    localparam logic [4:0] ALU_LSR = 5'b11100;
    localparam logic [4:0] ALU_XOR = 5'b11001;

    localparam logic [3:0] RF_NONE = 4'b0000;
    localparam logic [3:0] RF_R1   = 4'b1000;
    localparam logic [3:0] RF_R2   = 4'b0100;
    localparam logic [3:0] RF_R3   = 4'b0010;
    localparam logic [3:0] RF_R4   = 4'b0001;

    localparam logic [2:0] ARF_NONE = 3'b000;
    localparam logic [2:0] ARF_PC   = 3'b100;
    localparam logic [2:0] ARF_ALL  = 3'b111;

    localparam logic [1:0] ARF_SEL_PC = 2'b00;
    localparam logic [1:0] MUXA_ALU   = 2'b00;
    localparam logic [1:0] MUXA_IMM   = 2'b11;
    localparam logic [1:0] MUXB_IMM   = 2'b11;

    // RX counts from zero (00 -> R1), DST names the register directly (1 -> R1)
    function automatic logic [3:0] rx_regsel(input logic [1:0] rx);
        case (rx)
            2'd0:    rx_regsel = RF_R1;
            2'd1:    rx_regsel = RF_R2;
            2'd2:    rx_regsel = RF_R3;
            default: rx_regsel = RF_R4;
        endcase
    endfunction

    function automatic logic [3:0] dst_regsel(input logic [2:0] dst);
        case (dst)
            3'd1:    dst_regsel = RF_R1;
            3'd2:    dst_regsel = RF_R2;
            3'd3:    dst_regsel = RF_R3;
            3'd4:    dst_regsel = RF_R4;
            default: dst_regsel = RF_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_sequencer_decoder.sv
// rtl/control_unit_sequencer_decoder.sv - cu_decoder: opcode to {class, ALU function, EXEC length, illegal}
module cu_decoder
    import cu_pkg::*;
(
    input  logic [5:0] op,
    output op_class_t  op_class,
    output logic [4:0] alu_fun,
    output logic [1:0] exec_len,
    output logic       illegal
);

    always_comb begin
        op_class = CL_NONE;
        alu_fun  = 5'b00000;
        exec_len = 2'd0;
        illegal  = 1'b0;
        case (op)
            OP_BRA: begin op_class = CL_BRA; exec_len = 2'd1; end
            OP_BNE: begin op_class = CL_BNE; exec_len = 2'd1; end
            OP_LDI: begin op_class = CL_LDI; exec_len = 2'd1; end
            OP_HLT: begin op_class = CL_HLT; exec_len = 2'd1; end
            OP_AND: begin op_class = CL_ALU; exec_len = 2'd2; alu_fun = ALU_AND; end
            OP_OR:  begin op_class = CL_ALU; exec_len = 2'd2; alu_fun = ALU_OR;  end
            OP_NOT: begin op_class = CL_ALU; exec_len = 2'd2; alu_fun = ALU_NOT; end
            OP_ADD: begin op_class = CL_ALU; exec_len = 2'd2; alu_fun = ALU_ADD; end
            OP_SUB: begin op_class = CL_ALU; exec_len = 2'd2; alu_fun = ALU_SUB; end
            OP_LSL: begin op_class = CL_ALU; exec_len = 2'd2; alu_fun = ALU_LSL; end
            OP_LSR: begin op_class = CL_ALU; exec_len = 2'd2; alu_fun = ALU_LSR; end
            OP_XOR: begin op_class = CL_ALU; exec_len = 2'd2; alu_fun = ALU_XOR; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit_sequencer.sv
// rtl/control_unit_sequencer.sv - hardwired fetch/decode/execute sequencer for the ALU-system datapath
// CU_ILLEGAL_TRAP_EN: an undefined opcode halts instead of acting as a NOP.
module control_unit_sequencer
    import cu_pkg::*;
#(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic [15:0] IROut,
    input  logic [3:0]  Flags,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted,
    output logic        Illegal,
    output logic [2:0]  State
);

    state_t     state, state_next;
    logic [1:0] t, t_next;
    op_class_t  op_class;
    logic [4:0] alu_fun;
    logic [1:0] exec_len;
    logic       illegal;
    logic       exec_last;

    logic [5:0] op;
    logic       s_bit;
    logic [2:0] dst, sr1, sr2;
    logic [1:0] rx;
    logic       z_flag;

    assign op     = IROut[15:10];
    assign s_bit  = IROut[9];
    assign dst    = IROut[8:6];
    assign sr1    = IROut[5:3];
    assign sr2    = IROut[2:0];
    assign rx     = IROut[9:8];
    assign z_flag = Flags[3];

    // The ARF clear delivers the zero reset vector; only Z steers sequencing.
    logic unused_inputs;
    assign unused_inputs = ^{Flags[2:0], PC_RESET};

    cu_decoder u_decoder (
        .op       (op),
        .op_class (op_class),
        .alu_fun  (alu_fun),
        .exec_len (exec_len),
        .illegal  (illegal)
    );

    assign exec_last = (t == (exec_len - 2'd1)) || (t == 2'd3);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= RST;
            t     <= 2'd0;
        end else begin
            state <= state_next;
            t     <= t_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RST:     state_next = FETCH_L;
            FETCH_L: if (Run) state_next = FETCH_H;
            FETCH_H: state_next = DECODE;
            DECODE: begin
                if (illegal) begin
`ifdef CU_ILLEGAL_TRAP_EN
                    state_next = HALT;
`else
                    state_next = FETCH_L;
`endif
                end else if (exec_len == 2'd0) begin
                    state_next = FETCH_L;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC:    if (exec_last) state_next = (op_class == CL_HLT) ? HALT : FETCH_L;
            HALT:    state_next = HALT;
            default: state_next = RST;
        endcase
        t_next = ((state == EXEC) && (state_next == EXEC)) ? t + 2'd1 : 2'd0;
    end

    // Control word; Reset low forces the idle word even before the state register settles.
    always_comb begin
        RF_OutASel  = 3'd0;
        RF_OutBSel  = 3'd0;
        RF_FunSel   = FS_DEC;
        RF_RegSel   = RF_NONE;
        RF_ScrSel   = RF_NONE;
        ALU_FunSel  = 5'd0;
        ALU_WF      = 1'b0;
        ARF_OutCSel = ARF_SEL_PC;
        ARF_OutDSel = ARF_SEL_PC;
        ARF_FunSel  = FS_DEC;
        ARF_RegSel  = ARF_NONE;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        Illegal     = 1'b0;
        if (Reset) begin
            case (state)
                RST: begin
                    ARF_RegSel = ARF_ALL;
                    ARF_FunSel = FS_CLR;
                end
                FETCH_L, FETCH_H: begin
                    if (state == FETCH_H || Run) begin
                        ARF_OutDSel = ARF_SEL_PC;
                        Mem_CS      = 1'b0;
                        IR_Write    = 1'b1;
                        IR_LH       = (state == FETCH_H);
                        ARF_RegSel  = ARF_PC;
                        ARF_FunSel  = FS_INC;
                    end
                end
                DECODE: Illegal = illegal;
                EXEC: begin
                    case (op_class)
                        CL_BRA, CL_BNE: begin
                            if (op_class == CL_BRA || !z_flag) begin
                                MuxBSel    = MUXB_IMM;
                                ARF_FunSel = FS_LOAD;
                                ARF_RegSel = ARF_PC;
                            end
                        end
                        CL_LDI: begin
                            MuxASel   = MUXA_IMM;
                            RF_FunSel = FS_LOAD;
                            RF_RegSel = rx_regsel(rx);
                        end
                        CL_ALU: begin
                            // Operand selects and function stay up in T1 so ALUOut is stable for the write.
                            RF_OutASel = sr1;
                            RF_OutBSel = sr2;
                            ALU_FunSel = alu_fun;
                            if (t == 2'd0) begin
                                ALU_WF = s_bit;
                            end else begin
                                MuxASel   = MUXA_ALU;
                                RF_FunSel = FS_LOAD;
                                RF_RegSel = dst_regsel(dst);
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign State  = state;
    assign Halted = (state == HALT);

endmodule

// File: tb/tb_control_unit_sequencer.sv
// tb/tb_control_unit_sequencer.sv - directed vector bench for control_unit_sequencer
module tb_control_unit_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Run;
    logic [15:0] IROut;
    logic [3:0]  Flags;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted, Illegal;
    logic [2:0]  State;

    control_unit_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .IROut(IROut), .Flags(Flags),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
        .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
        .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
        .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
        .Halted(Halted), .Illegal(Illegal), .State(State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  flags;
        logic        run;
        logic [2:0]  st;
        logic [2:0]  oa, ob, rff;
        logic [3:0]  rreg;
        logic [4:0]  af;
        logic        wf;
        logic [1:0]  dsel;
        logic [2:0]  afun, areg;
        logic        lh, irw, cs, wr;
        logic [1:0]  ma, mb;
        logic        ill, hlt;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t v_idle(input logic [2:0] st, input logic [15:0] ir,
                                    input logic [3:0] fl, input logic run);
        vec_t v;
        v.ir = ir; v.flags = fl; v.run = run; v.st = st;
        v.oa = 3'd0; v.ob = 3'd0; v.rff = 3'd0; v.rreg = 4'd0;
        v.af = 5'd0; v.wf = 1'b0; v.dsel = 2'd0; v.afun = 3'd0; v.areg = 3'd0;
        v.lh = 1'b0; v.irw = 1'b0; v.cs = 1'b1; v.wr = 1'b0;
        v.ma = 2'd0; v.mb = 2'd0; v.ill = 1'b0; v.hlt = (st == 3'd5);
        return v;
    endfunction

    function automatic vec_t v_rst();
        vec_t v;
        v = v_idle(3'd0, 16'h0000, 4'h0, 1'b1);
        v.areg = 3'b111;
        v.afun = 3'b011;
        return v;
    endfunction

    function automatic vec_t v_fetch(input logic lh, input logic [15:0] ir);
        vec_t v;
        v = v_idle(lh ? 3'd2 : 3'd1, ir, 4'h0, 1'b1);
        v.cs = 1'b0; v.irw = 1'b1; v.lh = lh; v.dsel = 2'b00;
        v.areg = 3'b100; v.afun = 3'b001;
        return v;
    endfunction

    function automatic vec_t v_dec(input logic [15:0] ir, input logic ill);
        vec_t v;
        v = v_idle(3'd3, ir, 4'h0, 1'b1);
        v.ill = ill;
        return v;
    endfunction

    function automatic logic [46:0] pack(input vec_t v);
        return {v.st, v.oa, v.ob, v.rff, v.rreg, 4'h0, v.af, v.wf, 2'b00, v.dsel,
                v.afun, v.areg, v.lh, v.irw, v.cs, v.wr, v.ma, v.mb, 1'b0, v.ill, v.hlt};
    endfunction

    task automatic check(input string tag, input vec_t v);
        logic [46:0] got, exp;
        got = {State, RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Write, Mem_CS, Mem_WR, MuxASel, MuxBSel, MuxCSel, Illegal, Halted};
        exp = pack(v);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s ir=%h state=%0d got=%h expected=%h", tag, v.ir, State, got, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge Clock);
        IROut = v.ir;
        Flags = v.flags;
        Run   = v.run;
        #2;
        check(tag, v);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        Reset = 1'b0; Run = 1'b1; IROut = 16'h0000; Flags = 4'h0;

        // Fetch of a 3-cycle undefined op, Run=0 stall, then LDI
        tbl.push_back(v_fetch(1'b0, 16'h0C00));
        tbl.push_back(v_fetch(1'b1, 16'h0C00));
        tbl.push_back(v_dec(16'h0C00, 1'b1));
        tbl.push_back(v_idle(3'd1, 16'h0C00, 4'h0, 1'b0));
        tbl.push_back(v_idle(3'd1, 16'h0C00, 4'h0, 1'b0));
        tbl.push_back(v_fetch(1'b0, 16'h0955));
        tbl.push_back(v_fetch(1'b1, 16'h0955));
        tbl.push_back(v_dec(16'h0955, 1'b0));
        v = v_idle(3'd4, 16'h0955, 4'h0, 1'b1);
        v.ma = 2'b11; v.rff = 3'b010; v.rreg = 4'b0100;
        tbl.push_back(v);
        // ADD S=1 DST=1 SR1=2 SR2=3
        tbl.push_back(v_fetch(1'b0, 16'h1E53));
        tbl.push_back(v_fetch(1'b1, 16'h1E53));
        tbl.push_back(v_dec(16'h1E53, 1'b0));
        v = v_idle(3'd4, 16'h1E53, 4'h0, 1'b1);
        v.oa = 3'd2; v.ob = 3'd3; v.af = 5'b10100; v.wf = 1'b1;
        tbl.push_back(v);
        v.wf = 1'b0; v.ma = 2'b00; v.rff = 3'b010; v.rreg = 4'b1000;
        tbl.push_back(v);
        // BNE 0x20 with Z=1 (not taken) then Z=0 (taken)
        tbl.push_back(v_fetch(1'b0, 16'h0420));
        tbl.push_back(v_fetch(1'b1, 16'h0420));
        tbl.push_back(v_dec(16'h0420, 1'b0));
        tbl.push_back(v_idle(3'd4, 16'h0420, 4'b1111, 1'b1));
        tbl.push_back(v_fetch(1'b0, 16'h0420));
        tbl.push_back(v_fetch(1'b1, 16'h0420));
        tbl.push_back(v_dec(16'h0420, 1'b0));
        v = v_idle(3'd4, 16'h0420, 4'b0111, 1'b1);
        v.mb = 2'b11; v.afun = 3'b010; v.areg = 3'b100;
        tbl.push_back(v);
        // BRA is taken regardless of Z
        tbl.push_back(v_fetch(1'b0, 16'h0010));
        tbl.push_back(v_fetch(1'b1, 16'h0010));
        tbl.push_back(v_dec(16'h0010, 1'b0));
        v = v_idle(3'd4, 16'h0010, 4'b1000, 1'b1);
        v.mb = 2'b11; v.afun = 3'b010; v.areg = 3'b100;
        tbl.push_back(v);
        // HLT: EXEC then HALT, which ignores Run
        tbl.push_back(v_fetch(1'b0, 16'hFC00));
        tbl.push_back(v_fetch(1'b1, 16'hFC00));
        tbl.push_back(v_dec(16'hFC00, 1'b0));
        tbl.push_back(v_idle(3'd4, 16'hFC00, 4'h0, 1'b1));
        tbl.push_back(v_idle(3'd5, 16'hFC00, 4'h0, 1'b1));
        tbl.push_back(v_idle(3'd5, 16'h0C00, 4'h0, 1'b1));

        #3;
        check("reset_idle", v_idle(3'd0, 16'h0000, 4'h0, 1'b1));
        @(negedge Clock);
        Reset = 1'b1;
        #2;
        check("rst_word", v_rst());

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset during ALU EXEC T0 abandons the write
        @(negedge Clock);
        Reset = 1'b0;
        #2;
        check("halt_reset_idle", v_idle(3'd0, 16'hFC00, 4'h0, 1'b1));
        @(negedge Clock);
        Reset = 1'b1;
        #2;
        check("rst_word_2", v_rst());
        apply("abort_fl", v_fetch(1'b0, 16'h1E53));
        apply("abort_fh", v_fetch(1'b1, 16'h1E53));
        apply("abort_dec", v_dec(16'h1E53, 1'b0));
        v = v_idle(3'd4, 16'h1E53, 4'h0, 1'b1);
        v.oa = 3'd2; v.ob = 3'd3; v.af = 5'b10100; v.wf = 1'b1;
        apply("abort_t0", v);
        #1;
        Reset = 1'b0;
        #1;
        check("abort_idle", v_idle(3'd0, 16'h1E53, 4'h0, 1'b1));
        @(negedge Clock);
        #2;
        check("abort_held", v_idle(3'd0, 16'h1E53, 4'h0, 1'b1));
        Reset = 1'b1;
        #2;
        check("rst_word_3", v_rst());
        apply("restart_fl", v_fetch(1'b0, 16'hF800));
        apply("restart_fh", v_fetch(1'b1, 16'hF800));

        // Undefined opcode 0x3E
        apply("op3e_dec", v_dec(16'hF800, 1'b1));
`ifdef CU_ILLEGAL_TRAP_EN
        apply("op3e_halt", v_idle(3'd5, 16'hF800, 4'h0, 1'b1));
        apply("op3e_halt2", v_idle(3'd5, 16'hF800, 4'h0, 1'b1));
`else
        apply("op3e_next_fl", v_fetch(1'b0, 16'h0C00));
        apply("op3e_next_fh", v_fetch(1'b1, 16'h0C00));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
